// File: rtl/hsstl_rst4mcrsw_rx_rst_fsm.sv
// HSST single-lane receive reset sequencer.
// Steps the lane through sigdet, PMA reset, CDR lock, PCS reset and alignment.
module hsstl_rst4mcrsw_rx_rst_fsm #(
    parameter int CNTR_WIDTH   = 16,
    parameter int SIGDET_DEB   = 1024,
    parameter int CDR_DEB      = 2048,
    parameter int PMA_RST_HOLD = 64,
    parameter int PCS_RST_HOLD = 32,
    parameter int LOCK_TIMEOUT = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_rst_done,
    input  logic       rate,
    input  logic       P_RX_SIGDET_STATUS,
    input  logic       P_RX_READY,
    input  logic       P_PCS_LSM_SYNCED,
    output logic       P_PMA_RX_PD,
    output logic       P_PMA_RX_RST,
    output logic       P_PCS_RX_RST,
    output logic [2:0] P_RX_RATE,
    output logic [2:0] rx_fsm,
    output logic       rx_rst_done
);

    typedef enum logic [2:0] {
        S_PD         = 3'd0,
        S_SIGDET     = 3'd1,
        S_PMA_RST    = 3'd2,
        S_WAIT_CDR   = 3'd3,
        S_PCS_RST    = 3'd4,
        S_WAIT_ALIGN = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    localparam logic [CNTR_WIDTH-1:0] SIG_MAX  = CNTR_WIDTH'(SIGDET_DEB);
    localparam logic [CNTR_WIDTH-1:0] CDR_MAX  = CNTR_WIDTH'(CDR_DEB);
    localparam logic [CNTR_WIDTH-1:0] PMA_LAST = CNTR_WIDTH'(PMA_RST_HOLD - 1);
    localparam logic [CNTR_WIDTH-1:0] PCS_LAST = CNTR_WIDTH'(PCS_RST_HOLD - 1);
    localparam logic [CNTR_WIDTH-1:0] TO_LAST  = CNTR_WIDTH'(LOCK_TIMEOUT - 1);

    state_t                  state;
    state_t                  nxt;
    logic [1:0]              sig_sync;
    logic [1:0]              rdy_sync;
    logic [1:0]              lsm_sync;
    logic                    sig_s;
    logic                    rdy_s;
    logic                    lsm_s;
    logic [CNTR_WIDTH-1:0]   sig_cnt;
    logic [CNTR_WIDTH-1:0]   cdr_cnt;
    logic                    sigdet_deb;
    logic                    cdr_lock_deb;
    logic [CNTR_WIDTH-1:0]   timer;
    logic                    timer_run;
    logic                    rate_q;
    logic                    pd_d;
    logic                    pma_d;
    logic                    pcs_d;
    logic                    done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_sync <= 2'b00;
            rdy_sync <= 2'b00;
            lsm_sync <= 2'b00;
        end else begin
            sig_sync <= {sig_sync[0], P_RX_SIGDET_STATUS};
            rdy_sync <= {rdy_sync[0], P_RX_READY};
            lsm_sync <= {lsm_sync[0], P_PCS_LSM_SYNCED};
        end
    end

    assign sig_s = sig_sync[1];
    assign rdy_s = rdy_sync[1];
    assign lsm_s = lsm_sync[1];

    // Debounce: count consecutive synced highs, saturate at the limit.
    always_ff @(posedge clk) begin
        if (rst || !sig_s) begin
            sig_cnt <= '0;
        end else if (sig_cnt != SIG_MAX) begin
            sig_cnt <= sig_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !rdy_s) begin
            cdr_cnt <= '0;
        end else if (cdr_cnt != CDR_MAX) begin
            cdr_cnt <= cdr_cnt + 1'b1;
        end
    end

    assign sigdet_deb   = (sig_cnt == SIG_MAX);
    assign cdr_lock_deb = (cdr_cnt == CDR_MAX);

    assign timer_run = (state == S_PMA_RST) || (state == S_WAIT_CDR) ||
                       (state == S_PCS_RST) || (state == S_WAIT_ALIGN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_PD;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (nxt != state || !timer_run) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Rate is tracked while in PMA reset so a change there is absorbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rate_q <= 1'b0;
        end else if (nxt == S_PMA_RST) begin
            rate_q <= rate;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_PD: begin
                if (tx_rst_done) nxt = S_SIGDET;
            end
            S_SIGDET: begin
                if (sigdet_deb) nxt = S_PMA_RST;
            end
            S_PMA_RST: begin
                if (timer == PMA_LAST) nxt = S_WAIT_CDR;
            end
            S_WAIT_CDR: begin
                if (cdr_lock_deb) begin
                    nxt = S_PCS_RST;
                end else if (timer == TO_LAST) begin
                    nxt = S_PMA_RST;
                end
            end
            S_PCS_RST: begin
                if (timer == PCS_LAST) nxt = S_WAIT_ALIGN;
            end
            S_WAIT_ALIGN: begin
                if (lsm_s) begin
                    nxt = S_DONE;
                end else if (timer == TO_LAST) begin
                    nxt = S_PMA_RST;
                end
            end
            S_DONE: begin
                nxt = S_DONE;
            end
            default: begin
                nxt = S_PD;
            end
        endcase
        // Fault exits override the normal transition.
        if (state >= S_PMA_RST && state <= S_DONE) begin
            if (!tx_rst_done) begin
                nxt = S_PD;
            end else if (!sig_s) begin
                nxt = S_SIGDET;
            end else if (state >= S_WAIT_CDR && rate != rate_q) begin
                nxt = S_PMA_RST;
            end else if (state >= S_PCS_RST && !rdy_s) begin
                nxt = S_PMA_RST;
            end
        end
    end

    always_comb begin
        pd_d   = (nxt == S_PD);
        pma_d  = (nxt == S_PD) || (nxt == S_SIGDET) || (nxt == S_PMA_RST);
        pcs_d  = (nxt != S_WAIT_ALIGN) && (nxt != S_DONE);
        done_d = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            P_PMA_RX_PD  <= 1'b1;
            P_PMA_RX_RST <= 1'b1;
            P_PCS_RX_RST <= 1'b1;
            rx_rst_done  <= 1'b0;
        end else begin
            P_PMA_RX_PD  <= pd_d;
            P_PMA_RX_RST <= pma_d;
            P_PCS_RX_RST <= pcs_d;
            rx_rst_done  <= done_d;
        end
    end

    assign P_RX_RATE = {2'b00, rate_q};
    assign rx_fsm    = state;

endmodule

// File: tb/tb_hsstl_rst4mcrsw_rx_rst_fsm.sv
// Bench for the RX reset sequencer: vector table, corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_hsstl_rst4mcrsw_rx_rst_fsm;

    localparam int SDEB = 8;
    localparam int CDEB = 8;
    localparam int PMAH = 4;
    localparam int PCSH = 4;
    localparam int TOUT = 50;

    logic       clk;
    logic       i_rst;
    logic       i_txd;
    logic       i_rate;
    logic       i_sig;
    logic       i_rdy;
    logic       i_lsm;
    logic       pd;
    logic       pma;
    logic       pcs;
    logic [2:0] rxrate;
    logic [2:0] fsm;
    logic       done;

    int nvec = 0;
    int nerr = 0;

    hsstl_rst4mcrsw_rx_rst_fsm #(
        .CNTR_WIDTH(16),
        .SIGDET_DEB(SDEB),
        .CDR_DEB(CDEB),
        .PMA_RST_HOLD(PMAH),
        .PCS_RST_HOLD(PCSH),
        .LOCK_TIMEOUT(TOUT)
    ) dut (
        .clk(clk),
        .rst(i_rst),
        .tx_rst_done(i_txd),
        .rate(i_rate),
        .P_RX_SIGDET_STATUS(i_sig),
        .P_RX_READY(i_rdy),
        .P_PCS_LSM_SYNCED(i_lsm),
        .P_PMA_RX_PD(pd),
        .P_PMA_RX_RST(pma),
        .P_PCS_RX_RST(pcs),
        .P_RX_RATE(rxrate),
        .rx_fsm(fsm),
        .rx_rst_done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw-input history, run lengths, dwell time.
    int   m_st;
    int   m_dwell;
    int   m_srun;
    int   m_crun;
    logic m_rq;
    logic m_done;
    logic [1:0] m_hs;
    logic [1:0] m_hr;
    logic [1:0] m_hl;

    task automatic model_edge();
        int ns;
        logic ss;
        logic rs;
        logic ls;
        if (i_rst) begin
            m_st = 0; m_dwell = 0; m_srun = 0; m_crun = 0;
            m_rq = 1'b0; m_done = 1'b0;
            m_hs = 2'b00; m_hr = 2'b00; m_hl = 2'b00;
        end else begin
            ss = m_hs[1];
            rs = m_hr[1];
            ls = m_hl[1];
            ns = m_st;
            case (m_st)
                0: if (i_txd) ns = 1;
                1: if (m_srun >= SDEB) ns = 2;
                2: if (m_dwell == PMAH - 1) ns = 3;
                3: if (m_crun >= CDEB) ns = 4;
                   else if (m_dwell == TOUT - 1) ns = 2;
                4: if (m_dwell == PCSH - 1) ns = 5;
                5: if (ls) ns = 6;
                   else if (m_dwell == TOUT - 1) ns = 2;
                default: ns = m_st;
            endcase
            if (m_st >= 2) begin
                if (!i_txd) ns = 0;
                else if (!ss) ns = 1;
                else if (m_st >= 3 && i_rate != m_rq) ns = 2;
                else if (m_st >= 4 && !rs) ns = 2;
            end
            m_done = (m_st == 6);
            if (ns == 2) m_rq = i_rate;
            m_dwell = (ns != m_st) ? 0 : m_dwell + 1;
            m_srun = ss ? m_srun + 1 : 0;
            m_crun = rs ? m_crun + 1 : 0;
            m_hs = {m_hs[0], i_sig};
            m_hr = {m_hr[0], i_rdy};
            m_hl = {m_hl[0], i_lsm};
            m_st = ns;
        end
    endtask

    function automatic logic [9:0] outv();
        return {pd, pma, pcs, rxrate, fsm, done};
    endfunction

    function automatic logic [9:0] expv();
        logic [2:0] st;
        st = 3'(m_st);
        return {m_st == 0, m_st <= 2, m_st <= 4, 2'b00, m_rq, st, m_done};
    endfunction

    task automatic chk(input string name, input logic [9:0] got,
                       input logic [9:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    task automatic chk1(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", outv(), expv());
    endtask

    task automatic wait_fsm(input logic [2:0] tgt, input int lim);
        int n;
        n = 0;
        while (fsm !== tgt && n < lim) begin
            step();
            n++;
        end
        chk1("wait_fsm", int'(fsm), int'(tgt));
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic [5:0] in;
        int         n;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n;
        int bad;
        tbl[0]  = '{"reset",       6'b110111, 2, 10'b111_000_000_0};
        tbl[1]  = '{"pd_exit",     6'b010111, 1, 10'b011_000_001_0};
        tbl[2]  = '{"sigdet_deb",  6'b010111, 9, 10'b011_000_001_0};
        tbl[3]  = '{"pma_entry",   6'b010111, 1, 10'b011_000_010_0};
        tbl[4]  = '{"cdr_entry",   6'b010111, 4, 10'b001_000_011_0};
        tbl[5]  = '{"pcs_entry",   6'b010111, 1, 10'b001_000_100_0};
        tbl[6]  = '{"align_entry", 6'b010111, 4, 10'b000_000_101_0};
        tbl[7]  = '{"done_entry",  6'b010111, 1, 10'b000_000_110_0};
        tbl[8]  = '{"done_flag",   6'b010111, 1, 10'b000_000_110_1};
        tbl[9]  = '{"rate_fault",  6'b011111, 1, 10'b011_001_010_1};
        tbl[10] = '{"done_drop",   6'b011111, 1, 10'b011_001_010_0};
        tbl[11] = '{"rate_relock", 6'b011111, 3, 10'b001_001_011_0};

        {i_rst, i_txd, i_rate, i_sig, i_rdy, i_lsm} = 6'b110111;
        for (int k = 0; k < 12; k++) begin
            {i_rst, i_txd, i_rate, i_sig, i_rdy, i_lsm} = tbl[k].in;
            repeat (tbl[k].n) step();
            chk(tbl[k].name, outv(), tbl[k].exp);
        end

        // Rate change relock completes at 5G.
        wait_fsm(3'd6, 200);
        step();
        chk("relock_done", {rxrate, done}, 10'({3'b001, 1'b1}));

        // One-cycle sigdet drop while done.
        i_sig = 1'b0;
        step();
        i_sig = 1'b1;
        step();
        step();
        chk("sig_drop_fsm", {7'd0, fsm}, 10'd1);
        chk("sig_drop_pma", {9'd0, pma}, 10'd1);
        step();
        chk("sig_drop_done", {9'd0, done}, 10'd0);
        wait_fsm(3'd6, 200);
        step();
        chk("sig_relock", {9'd0, done}, 10'd1);

        // CDR never locks: 50-cycle timeout, repeating.
        i_rate = 1'b0;
        i_rdy = 1'b0;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            wait_fsm(3'd3, 100);
            n = 0;
            do begin
                step();
                n++;
            end while (fsm == 3'd3 && n < 100);
            chk1("cdr_timeout_len", n, TOUT);
            chk("cdr_retry", {pma, fsm}, 4'b1_010);
        end

        // Glitchy sigdet never debounces.
        i_rdy = 1'b1;
        do_reset();
        bad = 0;
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < 8; c++) begin
                i_sig = (c != 7);
                step();
                if (fsm != 3'd1) bad++;
            end
        end
        chk1("glitch_stuck", bad, 0);

        // rst mid-sequence, with 5G latched beforehand.
        i_sig = 1'b1;
        i_rate = 1'b1;
        do_reset();
        wait_fsm(3'd4, 100);
        i_rst = 1'b1;
        step();
        chk("mid_rst", outv(), 10'b111_000_000_0);
        i_rst = 1'b0;
        i_lsm = 1'b0;
        wait_fsm(3'd5, 100);
        i_txd = 1'b0;
        i_rate = 1'b0;
        step();
        chk("prio_a", {pd, fsm}, 4'b1_000);

        // Randomized traffic against the model.
        i_txd = 1'b1; i_sig = 1'b1; i_rdy = 1'b1; i_lsm = 1'b1;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            i_rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 299) == 0) i_txd = ~i_txd;
            if ($urandom_range(0, 399) == 0) i_rate = ~i_rate;
            if (i_sig) i_sig = ($urandom_range(0, 79) != 0);
            else i_sig = ($urandom_range(0, 2) == 0);
            if (i_rdy) i_rdy = ($urandom_range(0, 59) != 0);
            else i_rdy = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) i_lsm = ~i_lsm;
            if (!i_txd && $urandom_range(0, 9) == 0) i_txd = 1'b1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
